// File: rtl/pic_interrupt_sequencer_pkg.sv
// rtl/pic_interrupt_sequencer_pkg.sv - shared types, constants and priority encoder for the PIC sequencer
package pic_pkg;

  localparam int NUM_IRQ = 8;
  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    ACK2
  } pic_state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] level;
  } prio_t;

  // IR0 is the highest priority, so the lowest set index wins.
  function automatic prio_t prio_encode(input logic [NUM_IRQ-1:0] bits);
    prio_t r;
    r.found = 1'b0;
    r.level = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (bits[i]) begin
        r.found = 1'b1;
        r.level = 3'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pic_interrupt_sequencer_if.sv
// rtl/pic_interrupt_sequencer_if.sv - request, acknowledge, EOI and vector signals of the sequencer
interface pic_interrupt_sequencer_if;
  import pic_pkg::*;

  logic [NUM_IRQ-1:0] interrupt_request;
  logic [NUM_IRQ-1:0] interrupt_mask;
  logic [4:0]         vector_base;
  logic               auto_eoi;
  logic               inta;
  logic               eoi_valid;
  logic               eoi_specific;
  logic [2:0]         eoi_level;
  logic               int_out;
  logic [NUM_IRQ-1:0] irr_clear;
  logic [NUM_IRQ-1:0] in_service_register;
  logic               vector_valid;
  logic [7:0]         vector_data;

  modport master (
    output interrupt_request, interrupt_mask, vector_base, auto_eoi,
           inta, eoi_valid, eoi_specific, eoi_level,
    input  int_out, irr_clear, in_service_register, vector_valid, vector_data
  );

  modport slave (
    input  interrupt_request, interrupt_mask, vector_base, auto_eoi,
           inta, eoi_valid, eoi_specific, eoi_level,
    output int_out, irr_clear, in_service_register, vector_valid, vector_data
  );

endinterface

// File: rtl/pic_interrupt_sequencer_resolver.sv
// rtl/pic_interrupt_sequencer_resolver.sv - fixed-priority, fully nested eligibility against the ISR
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [NUM_IRQ-1:0] irr,
  input  logic [NUM_IRQ-1:0] imr,
  input  logic [NUM_IRQ-1:0] isr,
  output logic               eligible,
  output logic [2:0]         level
);

  prio_t              isr_top;
  prio_t              win;
  logic [NUM_IRQ-1:0] above_isr;

  assign isr_top = prio_encode(isr);

  // Only levels strictly above the highest in-service level may nest.
  always_comb begin
    above_isr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      above_isr[i] = !isr_top.found || (3'(i) < isr_top.level);
    end
  end

  assign win      = prio_encode(irr & ~imr & above_isr);
  assign eligible = win.found;
  assign level    = win.level;

endmodule

// File: rtl/pic_interrupt_sequencer.sv
// rtl/pic_interrupt_sequencer.sv - INT/INTA handshake, in-service register, EOI handling and vector output
module pic_interrupt_sequencer
  import pic_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  pic_interrupt_sequencer_if.slave bus
);

  pic_state_e         state_q, state_d;
  logic               int_out_q, int_out_d;
  logic [NUM_IRQ-1:0] irr_clear_q, irr_clear_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic               vector_valid_q, vector_valid_d;
  logic [7:0]         vector_data_q, vector_data_d;
  logic [2:0]         level_q, level_d;
  logic               spurious_q, spurious_d;

  logic               req_eligible;
  logic [2:0]         req_level;
  prio_t              isr_top;

  pic_priority_resolver u_resolver (
    .irr      (bus.interrupt_request),
    .imr      (bus.interrupt_mask),
    .isr      (isr_q),
    .eligible (req_eligible),
    .level    (req_level)
  );

  assign isr_top = prio_encode(isr_q);

  always_comb begin
    state_d        = state_q;
    int_out_d      = int_out_q;
    irr_clear_d    = '0;
    isr_d          = isr_q;
    vector_valid_d = 1'b0;
    vector_data_d  = vector_data_q;
    level_d        = level_q;
    spurious_d     = spurious_q;

    // EOI is resolved against the registered ISR so a same-cycle set lands on top of it.
    if (bus.eoi_valid) begin
      if (bus.eoi_specific) begin
        isr_d[bus.eoi_level] = 1'b0;
      end else if (isr_top.found) begin
        isr_d[isr_top.level] = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        if (req_eligible) begin
          int_out_d = 1'b1;
          state_d   = PENDING;
        end
      end
      PENDING: begin
        if (bus.inta) begin
          int_out_d = 1'b0;
          state_d   = ACK2;
          if (req_eligible) begin
            level_d          = req_level;
            spurious_d       = 1'b0;
            isr_d[req_level] = 1'b1;
            irr_clear_d      = NUM_IRQ'(1) << req_level;
          end else begin
            level_d    = SPURIOUS_LEVEL;
            spurious_d = 1'b1;
          end
        end
      end
      ACK2: begin
        if (bus.inta) begin
          vector_valid_d = 1'b1;
          vector_data_d  = {bus.vector_base, level_q};
          state_d        = IDLE;
          if (bus.auto_eoi && !spurious_q) begin
            isr_d[level_q] = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      int_out_q      <= 1'b0;
      irr_clear_q    <= '0;
      isr_q          <= '0;
      vector_valid_q <= 1'b0;
      vector_data_q  <= 8'h00;
      level_q        <= 3'd0;
      spurious_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      int_out_q      <= int_out_d;
      irr_clear_q    <= irr_clear_d;
      isr_q          <= isr_d;
      vector_valid_q <= vector_valid_d;
      vector_data_q  <= vector_data_d;
      level_q        <= level_d;
      spurious_q     <= spurious_d;
    end
  end

  assign bus.int_out             = int_out_q;
  assign bus.irr_clear           = irr_clear_q;
  assign bus.in_service_register = isr_q;
  assign bus.vector_valid        = vector_valid_q;
  assign bus.vector_data         = vector_data_q;

endmodule

// File: tb/tb_pic_interrupt_sequencer.sv
// tb/tb_pic_interrupt_sequencer.sv - table vectors, randomized model comparison and handshake corner cases
module tb_pic_interrupt_sequencer;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  pic_interrupt_sequencer_if bus ();

  pic_interrupt_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] irr;
    logic [7:0] imr;
    logic       inta;
    logic       eoi_v;
    logic       eoi_s;
    logic [2:0] eoi_l;
    logic       aeoi;
    logic       x_int;
    logic [7:0] x_isr;
    logic [7:0] x_clr;
    logic       x_vv;
    logic [7:0] x_vd;
  } vec_t;

  vec_t tbl[$];

  // Reference model: phase 0 = waiting, 1 = INT raised, 2 = between the two INTA pulses.
  int         m_phase;
  logic [7:0] m_isr;
  logic       m_int;
  int         m_level;
  logic       m_spur;
  logic [7:0] m_vd;
  logic [7:0] m_clr;
  logic       m_vv;

  function automatic vec_t mk(logic rst, logic [7:0] irr, logic [7:0] imr, logic inta,
                              logic eoi_v, logic eoi_s, logic [2:0] eoi_l, logic aeoi,
                              logic x_int, logic [7:0] x_isr, logic [7:0] x_clr,
                              logic x_vv, logic [7:0] x_vd);
    vec_t v;
    v.rst = rst; v.irr = irr; v.imr = imr; v.inta = inta;
    v.eoi_v = eoi_v; v.eoi_s = eoi_s; v.eoi_l = eoi_l; v.aeoi = aeoi;
    v.x_int = x_int; v.x_isr = x_isr; v.x_clr = x_clr; v.x_vv = x_vv; v.x_vd = x_vd;
    return v;
  endfunction

  function automatic int highest_set(logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int winning_request(logic [7:0] irr, logic [7:0] imr, logic [7:0] isr);
    int limit;
    limit = (highest_set(isr) < 0) ? 8 : highest_set(isr);
    for (int i = 0; i < limit; i++) if (irr[i] && !imr[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    int         top;
    int         win;
    logic [7:0] nisr;
    m_clr = 8'h00;
    m_vv  = 1'b0;
    if (reset) begin
      m_phase = 0; m_isr = 8'h00; m_int = 1'b0; m_level = 0; m_spur = 1'b0; m_vd = 8'h00;
      return;
    end
    top  = highest_set(m_isr);
    win  = winning_request(bus.interrupt_request, bus.interrupt_mask, m_isr);
    nisr = m_isr;
    if (bus.eoi_valid) begin
      if (bus.eoi_specific) nisr[bus.eoi_level] = 1'b0;
      else if (top >= 0) nisr[top] = 1'b0;
    end
    if (m_phase == 0) begin
      if (win >= 0) begin
        m_int = 1'b1; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (bus.inta) begin
        m_int = 1'b0; m_phase = 2;
        if (win >= 0) begin
          m_level = win; m_spur = 1'b0; nisr[win] = 1'b1; m_clr = 8'(1 << win);
        end else begin
          m_level = 7; m_spur = 1'b1;
        end
      end
    end else if (bus.inta) begin
      m_vv = 1'b1;
      m_vd = {bus.vector_base, 3'(m_level)};
      if (bus.auto_eoi && !m_spur) nisr[m_level] = 1'b0;
      m_phase = 0;
    end
    m_isr = nisr;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%02h expected=0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic rst, logic [7:0] irr, logic [7:0] imr, logic inta,
                       logic eoi_v, logic eoi_s, logic [2:0] eoi_l, logic aeoi);
    reset                 = rst;
    bus.interrupt_request = irr;
    bus.interrupt_mask    = imr;
    bus.inta              = inta;
    bus.eoi_valid         = eoi_v;
    bus.eoi_specific      = eoi_s;
    bus.eoi_level         = eoi_l;
    bus.auto_eoi          = aeoi;
  endtask

  initial begin
    int waited;
    n_checks = 0;
    n_fail   = 0;
    bus.vector_base = 5'h08;
    drive(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

    // rst irr imr inta ev es el ae | int isr clr vv vd
    tbl.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0,  0, 8'h00, 8'h00, 0, 8'h00));
    tbl.push_back(mk(0, 8'h08, 8'h00, 0, 0, 0, 0, 0,  1, 8'h00, 8'h00, 0, 8'h00));
    tbl.push_back(mk(0, 8'h08, 8'h00, 1, 0, 0, 0, 0,  0, 8'h08, 8'h08, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 0, 0,  0, 8'h08, 8'h00, 1, 8'h43));
    tbl.push_back(mk(0, 8'h20, 8'h00, 0, 0, 0, 0, 0,  0, 8'h08, 8'h00, 0, 8'h43));
    tbl.push_back(mk(0, 8'h22, 8'h00, 0, 0, 0, 0, 0,  1, 8'h08, 8'h00, 0, 8'h43));
    tbl.push_back(mk(0, 8'h22, 8'h00, 1, 0, 0, 0, 0,  0, 8'h0A, 8'h02, 0, 8'h43));
    tbl.push_back(mk(0, 8'h20, 8'h00, 1, 0, 0, 0, 0,  0, 8'h0A, 8'h00, 1, 8'h41));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 1, 0, 0, 0,  0, 8'h08, 8'h00, 0, 8'h41));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 1, 1, 3, 0,  0, 8'h00, 8'h00, 0, 8'h41));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 1, 1, 5, 0,  0, 8'h00, 8'h00, 0, 8'h41));
    tbl.push_back(mk(0, 8'h04, 8'h04, 0, 0, 0, 0, 0,  0, 8'h00, 8'h00, 0, 8'h41));
    tbl.push_back(mk(0, 8'h04, 8'h00, 0, 0, 0, 0, 0,  1, 8'h00, 8'h00, 0, 8'h41));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0,  1, 8'h00, 8'h00, 0, 8'h41));
    tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 0, 0,  0, 8'h00, 8'h00, 0, 8'h41));
    tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 0, 0,  0, 8'h00, 8'h00, 1, 8'h47));
    tbl.push_back(mk(0, 8'h01, 8'h00, 0, 0, 0, 0, 1,  1, 8'h00, 8'h00, 0, 8'h47));
    tbl.push_back(mk(0, 8'h01, 8'h00, 1, 0, 0, 0, 1,  0, 8'h01, 8'h01, 0, 8'h47));
    tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 0, 1,  0, 8'h00, 8'h00, 1, 8'h40));
    tbl.push_back(mk(0, 8'h10, 8'h00, 0, 0, 0, 0, 0,  1, 8'h00, 8'h00, 0, 8'h40));
    tbl.push_back(mk(0, 8'h10, 8'h00, 1, 0, 0, 0, 0,  0, 8'h10, 8'h10, 0, 8'h40));
    tbl.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0,  0, 8'h00, 8'h00, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 0, 0,  0, 8'h00, 8'h00, 0, 8'h00));
    tbl.push_back(mk(0, 8'h10, 8'h00, 0, 0, 0, 0, 0,  1, 8'h00, 8'h00, 0, 8'h00));
    tbl.push_back(mk(0, 8'h10, 8'h00, 1, 0, 0, 0, 0,  0, 8'h10, 8'h10, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 0, 0,  0, 8'h10, 8'h00, 1, 8'h44));
    tbl.push_back(mk(0, 8'h04, 8'h00, 0, 0, 0, 0, 0,  1, 8'h10, 8'h00, 0, 8'h44));
    tbl.push_back(mk(0, 8'h04, 8'h00, 1, 1, 0, 0, 0,  0, 8'h04, 8'h04, 0, 8'h44));
    tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 0, 0,  0, 8'h04, 8'h00, 1, 8'h42));

    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].irr, tbl[i].imr, tbl[i].inta,
            tbl[i].eoi_v, tbl[i].eoi_s, tbl[i].eoi_l, tbl[i].aeoi);
      tick();
      check($sformatf("tbl%0d_int", i), 8'(bus.int_out), 8'(tbl[i].x_int));
      check($sformatf("tbl%0d_isr", i), bus.in_service_register, tbl[i].x_isr);
      check($sformatf("tbl%0d_clr", i), bus.irr_clear, tbl[i].x_clr);
      check($sformatf("tbl%0d_vv", i), 8'(bus.vector_valid), 8'(tbl[i].x_vv));
      check($sformatf("tbl%0d_vd", i), bus.vector_data, tbl[i].x_vd);
    end

    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0) bus.vector_base = 5'($urandom);
      drive(($urandom_range(0, 99) == 0),
            8'($urandom) & 8'($urandom),
            8'($urandom) & 8'($urandom) & 8'($urandom),
            ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 7) == 0),
            1'($urandom),
            3'($urandom),
            ((c / 100) % 2 == 1));
      tick();
      check("rnd_int", 8'(bus.int_out), 8'(m_int));
      check("rnd_isr", bus.in_service_register, m_isr);
      check("rnd_clr", bus.irr_clear, m_clr);
      check("rnd_vv", 8'(bus.vector_valid), 8'(m_vv));
      check("rnd_vd", bus.vector_data, m_vd);
    end

    // Back-to-back INTA pulses, with a specific EOI hitting the level being set.
    bus.vector_base = 5'h1F;
    drive(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    tick();
    drive(1'b0, 8'h40, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    waited = 0;
    while (!bus.int_out && waited < 5) begin
      tick();
      waited++;
    end
    check("b2b_int_wait", 8'(bus.int_out), 8'h01);
    drive(1'b0, 8'h40, 8'h00, 1'b1, 1'b1, 1'b1, 3'd6, 1'b0);
    tick();
    check("setwins_isr", bus.in_service_register, 8'h40);
    check("setwins_clr", bus.irr_clear, 8'h40);
    drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    tick();
    check("b2b_vv", 8'(bus.vector_valid), 8'h01);
    check("b2b_vd", bus.vector_data, 8'hFE);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    tick();
    check("vd_hold_vv", 8'(bus.vector_valid), 8'h00);
    check("vd_hold", bus.vector_data, 8'hFE);
    check("hold_isr", bus.in_service_register, 8'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
